// File: rtl/ysyx_23060020_memarb_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
package ysyx_23060020_memarb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } state_e;

  localparam logic MID_IFU = 1'b0;
  localparam logic MID_LSU = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT = 255;
  localparam int unsigned CNT_W           = 8;

endpackage

// File: rtl/ysyx_23060020_rr_pick2.sv
// Two-input round-robin picker: on a tie the master not granted last wins.
module ysyx_23060020_rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_23060020_memarb.sv
// Shares one memory port between IFU (m0) and LSU (m1); one transaction at a time,
// with a response watchdog so a silent slave cannot stall the core.
module ysyx_23060020_memarb
  import ysyx_23060020_memarb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_valid,
  output logic            m0_ready,
  input  logic [AW-1:0]   m0_addr,
  input  logic            m0_wen,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wmask,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  output logic            m0_rerr,
  input  logic            m1_valid,
  output logic            m1_ready,
  input  logic [AW-1:0]   m1_addr,
  input  logic            m1_wen,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wmask,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic            m1_rerr,
  output logic            s_valid,
  input  logic            s_ready,
  output logic [AW-1:0]   s_addr,
  output logic            s_wen,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_wmask,
  input  logic            s_rvalid,
  input  logic [DW-1:0]   s_rdata
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic             last_grant_q;
  logic             owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [DW-1:0]    rdata_q;
  logic             rerr_q;
  logic [1:0]       grant;
  logic             accept;
  logic             win_id;
  logic             expired;

  ysyx_23060020_rr_pick2 u_pick (
    .valid      ({m1_valid, m0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign accept  = (state_q == StIdle) && (|grant);
  assign win_id  = grant[1];
  assign cnt_inc = cnt_q + 8'd1;
  assign expired = (cnt_inc == TimeoutCnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (|grant) state_d = StReq;
      StReq:   if (s_ready) state_d = StWait;
      StWait:  if (s_rvalid || expired) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= MID_IFU;
      owner_q      <= MID_IFU;
      s_addr       <= '0;
      s_wen        <= 1'b0;
      s_wdata      <= '0;
      s_wmask      <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      rerr_q       <= 1'b0;
    end else begin
      if (accept) begin
        last_grant_q <= win_id;
        owner_q      <= win_id;
        s_addr       <= win_id ? m1_addr  : m0_addr;
        s_wen        <= win_id ? m1_wen   : m0_wen;
        s_wdata      <= win_id ? m1_wdata : m0_wdata;
        s_wmask      <= win_id ? m1_wmask : m0_wmask;
      end
      if (state_q == StReq && s_ready) cnt_q <= '0;
      else if (state_q == StWait)      cnt_q <= cnt_inc;
      // s_rvalid is only honoured in WAIT; stale responses elsewhere are dropped
      if (state_q == StWait) begin
        if (s_rvalid) begin
          rdata_q <= s_rdata;
          rerr_q  <= 1'b0;
        end else if (expired) begin
          rdata_q <= '0;
          rerr_q  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    // Gate ready with reset so nothing looks accepted while the core is held.
    m0_ready  = rst && (state_q == StIdle) && grant[0];
    m1_ready  = rst && (state_q == StIdle) && grant[1];
    s_valid   = (state_q == StReq);
    m0_rvalid = (state_q == StResp) && (owner_q == MID_IFU);
    m1_rvalid = (state_q == StResp) && (owner_q == MID_LSU);
    m0_rdata  = rdata_q;
    m1_rdata  = rdata_q;
    m0_rerr   = rerr_q;
    m1_rerr   = rerr_q;
  end

endmodule

// File: tb/tb_ysyx_23060020_memarb.sv
// Scenario bench for the IFU/LSU arbiter with a transaction-level reference model.
module tb_ysyx_23060020_memarb;

  localparam int unsigned TO = 4;

  logic        clk, rst;
  logic        m0_valid, m0_ready, m0_wen, m0_rvalid, m0_rerr;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wmask;
  logic        m1_valid, m1_ready, m1_wen, m1_rvalid, m1_rerr;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wmask;
  logic        s_valid, s_ready, s_wen, s_rvalid;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wmask;

  int   checks = 0;
  int   errors = 0;
  logic model_last;

  ysyx_23060020_memarb #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wen(m0_wen),
    .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_rerr(m0_rerr),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wen(m1_wen),
    .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_rerr(m1_rerr),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wen(s_wen), .s_wdata(s_wdata),
    .s_wmask(s_wmask), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m0_valid = 0; m0_addr = '0; m0_wen = 0; m0_wdata = '0; m0_wmask = '0;
    m1_valid = 0; m1_addr = '0; m1_wen = 0; m1_wdata = '0; m1_wmask = '0;
    s_ready = 0; s_rvalid = 0; s_rdata = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    #2 rst = 0;
    tick(); tick();
    rst = 1;
    model_last = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1;
    idle_inputs();
    #2 rst = 0;
    m0_valid = 1; m1_valid = 1; s_rvalid = 1;
    #1;
    checks++;
    if ({m0_ready, m1_ready, m0_rvalid, m1_rvalid, m0_rerr, m1_rerr, s_valid, s_wen} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=00000000",
               {m0_ready, m1_ready, m0_rvalid, m1_rvalid, m0_rerr, m1_rerr, s_valid, s_wen});
    end
    checks++;
    if ({m0_rdata, m1_rdata, s_addr, s_wdata, s_wmask} !== '0) begin
      errors++;
      $display("FAIL reset_data got rdata=%h/%h addr=%h wdata=%h mask=%h want all 0",
               m0_rdata, m1_rdata, s_addr, s_wdata, s_wmask);
    end
    idle_inputs();
    tick(); tick();
    rst = 1;
    model_last = 1'b0;
  endtask

  task automatic test_m0_read;
    m0_valid = 1; m0_addr = 32'h8000_0000; m0_wen = 0;
    #1;
    checks++;
    if ({m1_ready, m0_ready} !== 2'b01) begin
      errors++; $display("FAIL m0rd_ready got=%b want=01", {m1_ready, m0_ready});
    end
    model_last = 1'b0;
    tick();
    m0_valid = 0; m0_addr = '0; s_ready = 1;
    #1;
    checks++;
    if (s_valid !== 1 || s_addr !== 32'h8000_0000 || s_wen !== 0) begin
      errors++; $display("FAIL m0rd_req got v=%b a=%h w=%b want 1 80000000 0", s_valid, s_addr, s_wen);
    end
    tick();
    s_ready = 0; s_rvalid = 1; s_rdata = 32'h0010_0073;
    #1;
    checks++;
    if (m0_rvalid !== 0) begin
      errors++; $display("FAIL m0rd_early got=%b want=0", m0_rvalid);
    end
    tick();
    s_rvalid = 0; s_rdata = '0;
    checks++;
    if (m0_rvalid !== 1 || m1_rvalid !== 0 || m0_rdata !== 32'h0010_0073 || m0_rerr !== 0) begin
      errors++;
      $display("FAIL m0rd_resp got rv=%b/%b data=%h err=%b want 1/0 00100073 0",
               m0_rvalid, m1_rvalid, m0_rdata, m0_rerr);
    end
    tick();
    checks++;
    if (m0_rvalid !== 0 || s_valid !== 0) begin
      errors++; $display("FAIL m0rd_idle got rv=%b sv=%b want 0 0", m0_rvalid, s_valid);
    end
  endtask

  task automatic test_tie_rr;
    logic exp_w;
    do_reset();
    m0_valid = 1; m0_addr = 32'h0000_1000;
    m1_valid = 1; m1_addr = 32'h0000_2000;
    for (int i = 0; i < 4; i++) begin
      exp_w = ~model_last;
      model_last = exp_w;
      #1;
      checks++;
      if ({m1_ready, m0_ready} !== (exp_w ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL tie_grant i=%0d got=%b want m%0d", i, {m1_ready, m0_ready}, exp_w);
      end
      tick();
      s_ready = 1;
      #1;
      checks++;
      if (s_addr !== (exp_w ? 32'h0000_2000 : 32'h0000_1000) || {m1_ready, m0_ready} !== 2'b00) begin
        errors++; $display("FAIL tie_addr i=%0d got=%h rdy=%b", i, s_addr, {m1_ready, m0_ready});
      end
      tick();
      s_ready = 0; s_rvalid = 1; s_rdata = i;
      tick();
      s_rvalid = 0;
      checks++;
      if ({m1_rvalid, m0_rvalid} !== (exp_w ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL tie_resp i=%0d got=%b want m%0d", i, {m1_rvalid, m0_rvalid}, exp_w);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_write_delay;
    m1_valid = 1; m1_addr = 32'h8000_0100; m1_wen = 1; m1_wdata = 32'hDEAD_BEEF; m1_wmask = 4'hF;
    #1;
    checks++;
    if (m1_ready !== 1) begin
      errors++; $display("FAIL wr_ready got=%b want=1", m1_ready);
    end
    model_last = 1'b1;
    tick();
    m1_valid = 0; m1_addr = '0; m1_wen = 0; m1_wdata = '0; m1_wmask = '0;
    for (int k = 0; k < 4; k++) begin
      s_ready = (k == 3);
      #1;
      checks++;
      if (s_valid !== 1 || s_addr !== 32'h8000_0100 || s_wen !== 1 || s_wdata !== 32'hDEAD_BEEF
          || s_wmask !== 4'hF) begin
        errors++;
        $display("FAIL wr_stable k=%0d got v=%b a=%h w=%b d=%h m=%h", k, s_valid, s_addr, s_wen,
                 s_wdata, s_wmask);
      end
      tick();
    end
    s_ready = 0; s_rvalid = 1; s_rdata = 32'h1234_5678;
    tick();
    s_rvalid = 0;
    checks++;
    if (m1_rvalid !== 1 || m0_rvalid !== 0 || m1_rerr !== 0) begin
      errors++; $display("FAIL wr_resp got rv=%b/%b err=%b want 1/0 0", m1_rvalid, m0_rvalid, m1_rerr);
    end
    tick();
  endtask

  task automatic test_timeout;
    m1_valid = 1; m1_addr = 32'h8000_0200;
    tick();
    model_last = 1'b1;
    m1_valid = 0; s_ready = 1;
    tick();
    s_ready = 0;
    for (int k = 0; k < int'(TO); k++) begin
      checks++;
      if (m1_rvalid !== 0) begin
        errors++; $display("FAIL to_early k=%0d got=%b want=0", k, m1_rvalid);
      end
      tick();
    end
    checks++;
    if (m1_rvalid !== 1 || m1_rdata !== 32'h0 || m1_rerr !== 1) begin
      errors++;
      $display("FAIL to_resp got rv=%b data=%h err=%b want 1 0 1", m1_rvalid, m1_rdata, m1_rerr);
    end
    tick();
    s_rvalid = 1; s_rdata = 32'hFFFF_FFFF;
    tick();
    s_rvalid = 0;
    checks++;
    if (m1_rvalid !== 0 || m0_rvalid !== 0 || s_valid !== 0) begin
      errors++; $display("FAIL to_stray got rv=%b/%b sv=%b want 0", m1_rvalid, m0_rvalid, s_valid);
    end
    m1_valid = 1; m1_addr = 32'h8000_0300;
    tick();
    m1_valid = 0; s_ready = 1;
    tick();
    s_ready = 0; s_rvalid = 1; s_rdata = 32'hCAFE_0001;
    tick();
    s_rvalid = 0;
    checks++;
    if (m1_rvalid !== 1 || m1_rdata !== 32'hCAFE_0001 || m1_rerr !== 0) begin
      errors++;
      $display("FAIL to_next got rv=%b data=%h err=%b want 1 cafe0001 0", m1_rvalid, m1_rdata, m1_rerr);
    end
    tick();
  endtask

  task automatic test_m0_during_wait;
    m1_valid = 1; m1_addr = 32'h8000_0400;
    tick();
    m1_valid = 0; s_ready = 1;
    tick();
    s_ready = 0; m0_valid = 1; m0_addr = 32'h8000_0500;
    #1;
    checks++;
    if (m0_ready !== 0) begin
      errors++; $display("FAIL mw_wait0 got=%b want=0", m0_ready);
    end
    tick();
    checks++;
    if (m0_ready !== 0) begin
      errors++; $display("FAIL mw_wait1 got=%b want=0", m0_ready);
    end
    s_rvalid = 1; s_rdata = 32'h55;
    tick();
    s_rvalid = 0;
    checks++;
    if (m0_ready !== 0 || m1_rvalid !== 1) begin
      errors++; $display("FAIL mw_resp got rdy=%b rv1=%b want 0 1", m0_ready, m1_rvalid);
    end
    tick();
    checks++;
    if (m0_ready !== 1) begin
      errors++; $display("FAIL mw_accept got=%b want=1", m0_ready);
    end
    tick();
    model_last = 1'b0;
    m0_valid = 0; s_ready = 1;
    checks++;
    if (s_addr !== 32'h8000_0500) begin
      errors++; $display("FAIL mw_addr got=%h want=80000500", s_addr);
    end
    tick();
    s_ready = 0; s_rvalid = 1; s_rdata = 32'h66;
    tick();
    s_rvalid = 0;
    checks++;
    if (m0_rvalid !== 1 || m0_rdata !== 32'h66) begin
      errors++; $display("FAIL mw_m0resp got rv=%b data=%h want 1 66", m0_rvalid, m0_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait;
    m1_valid = 1; m1_addr = 32'h8000_0600;
    tick();
    m1_valid = 0; s_ready = 1;
    tick();
    s_ready = 0;
    #2 rst = 0;
    #1;
    checks++;
    if ({s_valid, m0_ready, m1_ready, m0_rvalid, m1_rvalid, m1_rerr} !== 6'b0
        || s_addr !== 0 || m1_rdata !== 0) begin
      errors++;
      $display("FAIL rmw_zero got sv=%b rv1=%b addr=%h data=%h want 0", s_valid, m1_rvalid, s_addr,
               m1_rdata);
    end
    tick();
    rst = 1;
    model_last = 1'b0;
    s_rvalid = 1; s_rdata = 32'h7777_7777;
    for (int k = 0; k < 3; k++) begin
      tick();
      s_rvalid = 0;
      checks++;
      if (m1_rvalid !== 0 || m0_rvalid !== 0 || s_valid !== 0) begin
        errors++; $display("FAIL rmw_drop k=%0d got rv=%b/%b sv=%b", k, m1_rvalid, m0_rvalid, s_valid);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0]  v;
    logic        exp_w, exp_wen, exp_err;
    logic [31:0] exp_addr, exp_wdata, rd, exp_data;
    logic [3:0]  exp_mask;
    int          rdy_d, rv_d;
    for (int it = 0; it < 60; it++) begin
      v = 2'($urandom_range(1, 3));
      m0_valid = v[0]; m0_addr = $urandom; m0_wen = 1'($urandom); m0_wdata = $urandom;
      m0_wmask = 4'($urandom);
      m1_valid = v[1]; m1_addr = $urandom; m1_wen = 1'($urandom); m1_wdata = $urandom;
      m1_wmask = 4'($urandom);
      exp_w     = (v == 2'b11) ? ~model_last : v[1];
      model_last = exp_w;
      exp_addr  = exp_w ? m1_addr : m0_addr;
      exp_wen   = exp_w ? m1_wen : m0_wen;
      exp_wdata = exp_w ? m1_wdata : m0_wdata;
      exp_mask  = exp_w ? m1_wmask : m0_wmask;
      rdy_d = $urandom_range(0, 3);
      rv_d  = $urandom_range(0, 5);
      rd    = $urandom;
      #1;
      checks++;
      if ({m1_ready, m0_ready} !== (exp_w ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rnd_grant it=%0d got=%b want m%0d", it, {m1_ready, m0_ready}, exp_w);
      end
      tick();
      m0_valid = 0; m1_valid = 0; m0_addr = $urandom; m1_addr = $urandom;
      for (int k = 0; k <= rdy_d; k++) begin
        s_ready = (k == rdy_d); s_rvalid = 1'($urandom); s_rdata = $urandom;
        #1;
        checks++;
        if (s_valid !== 1 || s_addr !== exp_addr || s_wen !== exp_wen || s_wdata !== exp_wdata
            || s_wmask !== exp_mask) begin
          errors++;
          $display("FAIL rnd_req it=%0d got a=%h w=%b d=%h m=%h want %h %b %h %h", it, s_addr, s_wen,
                   s_wdata, s_wmask, exp_addr, exp_wen, exp_wdata, exp_mask);
        end
        tick();
      end
      s_ready = 0; s_rvalid = 0;
      for (int k = 0; k < int'(TO); k++) begin
        if (k == rv_d) begin
          s_rvalid = 1; s_rdata = rd;
        end
        checks++;
        if (m0_rvalid !== 0 || m1_rvalid !== 0) begin
          errors++; $display("FAIL rnd_early it=%0d k=%0d got=%b want 00", it, k, {m1_rvalid, m0_rvalid});
        end
        tick();
        s_rvalid = 0;
        if (k == rv_d) break;
      end
      exp_err  = (rv_d >= int'(TO));
      exp_data = exp_err ? 32'h0 : rd;
      checks++;
      if ({m1_rvalid, m0_rvalid} !== (exp_w ? 2'b10 : 2'b01)
          || (exp_w ? m1_rdata : m0_rdata) !== exp_data || (exp_w ? m1_rerr : m0_rerr) !== exp_err) begin
        errors++;
        $display("FAIL rnd_resp it=%0d got rv=%b data=%h err=%b want m%0d %h %b", it,
                 {m1_rvalid, m0_rvalid}, exp_w ? m1_rdata : m0_rdata, exp_w ? m1_rerr : m0_rerr,
                 exp_w, exp_data, exp_err);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    model_last = 1'b0;
    test_reset();
    test_m0_read();
    test_tie_rr();
    test_write_delay();
    test_timeout();
    test_m0_during_wait();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060020_memarb.md
# ysyx_23060020_memarb

Two-master memory arbiter/sequencer that shares the single data-memory port between instruction fetch (master 0, IFU) and load/store (master 1, LSU) once the core moves from the single-cycle DPI memory model to a multi-cycle bus. It accepts one request at a time, latches it, drives it onto the slave port, waits for the response and routes it back to the requester. It includes a response watchdog so a dead slave cannot hang the core.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, max cycles waited for s_rvalid after slave acceptance (1..255)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- m0_valid/m1_valid  in  1  request valid (IFU/LSU)
- m0_ready/m1_ready  out  1  request accepted this cycle
- m0_addr/m1_addr  in  AW  request address
- m0_wen/m1_wen  in  1  1 = write (m0_wen is tied 0 by IFU but honoured)
- m0_wdata/m1_wdata  in  DW  write data
- m0_wmask/m1_wmask  in  DW/8  byte write mask
- m0_rvalid/m1_rvalid  out  1  one-cycle response pulse
- m0_rdata/m1_rdata  out  DW  read data, valid with rvalid
- m0_rerr/m1_rerr  out  1  response was a timeout, valid with rvalid
- s_valid  out  1  request to memory
- s_ready  in  1  memory accepts request
- s_addr, s_wen, s_wdata, s_wmask  out  AW/1/DW/DW/8  latched request fields
- s_rvalid  in  1  memory response (also for writes)
- s_rdata  in  DW  memory read data

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: if any mX_valid, grant one; mX_ready=1 combinationally for the winner only; latch addr/wen/wdata/wmask and owner id; go REQ. Otherwise stay.
- Arbitration: single valid wins; both valid → grant the master not granted last (round-robin). last_grant resets to 0, so the first tie goes to LSU (m1).
- REQ: s_valid=1 with latched fields, held stable until s_ready; on s_ready go WAIT, clear watchdog counter.
- WAIT: on s_rvalid capture s_rdata, rerr=0, go RESP. Else counter+1; when counter reaches TIMEOUT, capture rdata=0, rerr=1, go RESP.
- RESP: mX_rvalid=1 for owner only, one cycle; rdata/rerr from capture register; go IDLE.
- s_rvalid outside WAIT is ignored (late responses after timeout or reset are dropped).
- mX_ready is 0 in REQ, WAIT and RESP; requesters hold valid and fields until ready.
- Reset (async, any state): state=IDLE, last_grant=0, counter=0, capture regs=0; all outputs 0 (s_valid, mX_ready, mX_rvalid, mX_rerr, rdata, s_* fields). In-flight transaction is abandoned, no response is issued.
- Counter: 8 bits, saturating not required (leaves WAIT at TIMEOUT).

## Timing
- Accept at cycle N (IDLE) → s_valid from N+1.
- With s_ready at N+1 and s_rvalid at N+2 → mX_rvalid at N+3, IDLE at N+4; minimum 4 cycles per transaction, next accept earliest N+4.
- Timeout: s_ready at cycle A → rerr pulse at A+TIMEOUT+1... exactly when counter hits TIMEOUT, RESP the following cycle.
- mX_rdata/mX_rerr are registered; mX_ready is the only combinational output (depends on valids, state, last_grant).
- s_* fields are registered, stable through REQ.

## Structure
- Package ysyx_23060020_memarb_pkg: state enum (IDLE, REQ, WAIT, RESP), master id constants (MID_IFU=0, MID_LSU=1), default TIMEOUT.
- One sub-module: ysyx_23060020_rr_pick2 (2-input round-robin picker: valids + last_grant → grant one-hot).
- Top holds FSM, request latch, watchdog counter, response capture.

## Test plan
- Reset mid-WAIT (m1 read in flight, assert rst low) → all outputs 0 immediately; later s_rvalid ignored; no m1_rvalid.
- m0 read addr 0x8000_0000, s_ready same cycle as s_valid, s_rvalid next cycle with 0x0010_0073 → m0_rvalid at N+3, m0_rdata=0x0010_0073, m1_rvalid stays 0.
- m0 and m1 valid together from reset, held → grants m1, m0, m1, m0 alternately; s_addr sequence matches.
- m1 write addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 0xF, s_ready delayed 3 cycles → s_* fields stable through delay, m1_rvalid after s_rvalid, rerr=0.
- m1 read, slave never asserts s_rvalid, TIMEOUT=4 → m1_rvalid with m1_rdata=0, m1_rerr=1; later stray s_rvalid ignored; next request proceeds normally.
- m0_valid raised while m1 transaction in WAIT → m0_ready stays 0 until IDLE, then m0 accepted.
